// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with merged ALUOp/func7/func3 decode.
// Single-cycle integer ops complete one cycle after accept. With ALU_MDEXT_EN
// defined, the RV32M group runs on an iterative shift-add multiplier and a
// restoring divider. Without the macro, func7=0000001 decodes as illegal.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operation offer / accept handshake
//   alu_op             00 add, 01 sub, 10 R-type decode, 11 add
//   func7, func3       R-type function fields (used only when alu_op=10)
//   op_a, op_b         operands
//   out_valid/out_ready result handshake
//   result, zero       registered result and result==0 flag
//   illegal            unsupported encoding (result forced to 0)
//   busy               multi-cycle multiply/divide in progress
module alu_exec_unit #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MUL_STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);
  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d, ill_q, ill_d, vld_q, vld_d;
  logic            accept;
  logic [XLEN-1:0] sc_res, sc_out;
  logic            sc_ill;
  logic [SHW-1:0]  shamt;

`ifdef ALU_MDEXT_EN
  localparam int unsigned DW  = 2 * XLEN;
  localparam int unsigned CW  = $clog2(XLEN) + 1;
  localparam int unsigned NIT = XLEN / MUL_STEP_BITS;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            m_start, d_start, sel_hi, sign_a, sign_b, d_rem;
  logic            busy_q, busy_d;
  logic [DW-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_nx, prod;
  logic [XLEN-1:0] mplier_q, mplier_d, mag_a, mag_b;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fin, r_fin;
  logic [XLEN:0]   r_sh, r_diff;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d, rneg_q, rneg_d, sel_q, sel_d;
`endif

  // Operation decode and single-cycle result.
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    shamt  = op_b[SHW-1:0];
`ifdef ALU_MDEXT_EN
    m_start = 1'b0;
    d_start = 1'b0;
    sel_hi  = 1'b0;
    sign_a  = 1'b0;
    sign_b  = 1'b0;
    d_rem   = 1'b0;
`endif
    case (alu_op)
      2'b01: sc_res = op_a - op_b;
      2'b10: begin
        if (func7 == 7'b0000000) begin
          case (func3)
            3'b000:  sc_res = op_a + op_b;
            3'b001:  sc_res = op_a << shamt;
            3'b010:  sc_res = XLEN'($signed(op_a) < $signed(op_b));
            3'b011:  sc_res = XLEN'(op_a < op_b);
            3'b100:  sc_res = op_a ^ op_b;
            3'b101:  sc_res = op_a >> shamt;
            3'b110:  sc_res = op_a | op_b;
            default: sc_res = op_a & op_b;
          endcase
        end else if (func7 == 7'b0100000) begin
          case (func3)
            3'b000:  sc_res = op_a - op_b;
            3'b101:  sc_res = XLEN'($signed(op_a) >>> shamt);
            default: sc_ill = 1'b1;
          endcase
        end else if (func7 == 7'b0000001) begin
`ifdef ALU_MDEXT_EN
          if (!func3[2]) begin
            m_start = 1'b1;
            sel_hi  = (func3 != 3'b000);
            sign_a  = (func3 != 3'b011);
            sign_b  = !func3[1];
          end else begin
            sign_a = !func3[0];
            sign_b = !func3[0];
            d_rem  = func3[1];
            // Divide-by-zero and signed overflow resolve without iterating.
            if (op_b == '0) begin
              sc_res = d_rem ? op_a : '1;
            end else if (sign_a && (op_a == MIN_NEG) && (op_b == '1)) begin
              sc_res = d_rem ? '0 : op_a;
            end else begin
              d_start = 1'b1;
            end
          end
`else
          sc_ill = 1'b1;
`endif
        end else begin
          sc_ill = 1'b1;
        end
      end
      default: sc_res = op_a + op_b;
    endcase
  end

  assign sc_out   = sc_ill ? '0 : sc_res;
  assign in_ready = (state_q == S_IDLE) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_MDEXT_EN
  // Magnitudes of the operands; signedness is chosen by the decode.
  assign mag_a  = (sign_a && op_a[XLEN-1]) ? -op_a : op_a;
  assign mag_b  = (sign_b && op_b[XLEN-1]) ? -op_b : op_b;
  // Shift-add step: accumulate the multiplicand scaled by the low multiplier digit.
  assign acc_nx = acc_q + mcand_q * DW'(mplier_q[MUL_STEP_BITS-1:0]);
  assign prod   = neg_q ? -acc_nx : acc_nx;
  // Restoring step: trial-subtract the divisor from the shifted partial remainder.
  assign r_sh   = {rem_q, quo_q[XLEN-1]};
  assign r_diff = r_sh - {1'b0, dvs_q};
  assign rem_nx = r_diff[XLEN] ? r_sh[XLEN-1:0] : r_diff[XLEN-1:0];
  assign quo_nx = {quo_q[XLEN-2:0], !r_diff[XLEN]};
  assign q_fin  = neg_q ? -quo_nx : quo_nx;
  assign r_fin  = rneg_q ? -rem_nx : rem_nx;
`endif

  // Next-state and result-register logic.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    vld_d   = vld_q && !out_ready;
`ifdef ALU_MDEXT_EN
    busy_d   = busy_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    sel_d    = sel_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_MDEXT_EN
          if (m_start) begin
            state_d  = S_MUL;
            busy_d   = 1'b1;
            acc_d    = '0;
            mcand_d  = DW'(mag_a);
            mplier_d = mag_b;
            neg_d    = (sign_a && op_a[XLEN-1]) ^ (sign_b && op_b[XLEN-1]);
            sel_d    = sel_hi;
            cnt_d    = '0;
          end else if (d_start) begin
            state_d = S_DIV;
            busy_d  = 1'b1;
            rem_d   = '0;
            quo_d   = mag_a;
            dvs_d   = mag_b;
            neg_d   = (sign_a && op_a[XLEN-1]) ^ (sign_b && op_b[XLEN-1]);
            rneg_d  = sign_a && op_a[XLEN-1];
            sel_d   = d_rem;
            cnt_d   = '0;
          end else
`endif
          begin
            res_d  = sc_out;
            zero_d = (sc_out == '0);
            ill_d  = sc_ill;
            vld_d  = 1'b1;
          end
        end
      end
`ifdef ALU_MDEXT_EN
      S_MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << MUL_STEP_BITS;
        mplier_d = mplier_q >> MUL_STEP_BITS;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(NIT - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          res_d   = sel_q ? prod[DW-1:XLEN] : prod[XLEN-1:0];
          zero_d  = (res_d == '0);
          ill_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          res_d   = sel_q ? r_fin : q_fin;
          zero_d  = (res_d == '0);
          ill_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef ALU_MDEXT_EN
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      sel_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      vld_q   <= vld_d;
`ifdef ALU_MDEXT_EN
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      sel_q    <= sel_d;
`endif
    end
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;
`ifdef ALU_MDEXT_EN
  assign busy      = busy_q;
`else
  assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN=32, MUL_STEP_BITS=1).
// Expectations follow ALU_MDEXT_EN: with it undefined every M-group op is illegal.
module tb_alu_exec_unit;
`ifdef ALU_MDEXT_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [6:0]  func7;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        busy;

  alu_exec_unit #(.XLEN(32), .MUL_STEP_BITS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func7(func7), .func3(func3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    bit          ill;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input bit ill);
    vec_t v;
    v.op = op; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
    v.r = ill ? 32'd0 : r; v.ill = ill; v.lat = 1;
    vt.push_back(v);
  endtask

  // M-group row: expected values apply only when the extension is built in.
  task automatic add_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat);
    vec_t v;
    v.op = 2'b10; v.f7 = 7'b0000001; v.f3 = f3; v.a = a; v.b = b;
    v.r = MD_EN ? r : 32'd0; v.ill = !MD_EN; v.lat = MD_EN ? lat : 1;
    vt.push_back(v);
  endtask

  // Reference model built from the instruction semantics with wide integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit ill, output int lat);
    int          sa, sb;
    logic [63:0] p;
    sa = a; sb = b; r = 32'd0; ill = 1'b0; lat = 1;
    if (op == 2'b01) r = a - b;
    else if (op != 2'b10) r = a + b;
    else if (f7 == 7'h00) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
    else if (f7 == 7'h20 && f3 == 3'd5) r = 32'(sa >>> b[4:0]);
    else if (f7 == 7'h01 && MD_EN) begin
      lat = 33;
      case (f3)
        3'd0: begin p = 64'(longint'(sa) * longint'(sb)); r = p[31:0]; end
        3'd1: begin p = 64'(longint'(sa) * longint'(sb)); r = p[63:32]; end
        3'd2: begin p = 64'(longint'(sa) * longint'({32'd0, b})); r = p[63:32]; end
        3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
        3'd4: if (b == 0) begin r = '1; lat = 1; end
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; lat = 1; end
              else r = 32'(sa / sb);
        3'd5: if (b == 0) begin r = '1; lat = 1; end else r = a / b;
        3'd6: if (b == 0) begin r = a; lat = 1; end
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 0; lat = 1; end
              else r = 32'(sa % sb);
        default: if (b == 0) begin r = a; lat = 1; end else r = a % b;
      endcase
    end else ill = 1'b1;
    if (ill) r = 32'd0;
  endfunction

  // Offer one op with out_ready=1 and check result, flags, latency and busy span.
  task automatic do_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input bit eill, input int elat, input string tag);
    int cyc;
    int bcnt;
    @(negedge clk);
    alu_op = op; func7 = f7; func3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1; bcnt = 0;
    while (!out_valid && cyc < 200) begin
      if (busy && !in_ready) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(elat));
    chk({tag, " result"}, result, er);
    chk({tag, " illegal"}, 32'(illegal), 32'(eill));
    chk({tag, " zero"}, 32'(zero), 32'(er == 32'd0));
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(elat - 1));
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [6:0]  rf7;
    logic [2:0]  rf3;
    logic [31:0] ra, rb, er;
    bit          eill;
    int          elat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; func7 = 7'd0; func3 = 3'd0; op_a = 32'd0; op_b = 32'd0;

    // Directed vectors.
    add_v(2'b00, 7'h00, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0);
    add_v(2'b01, 7'h00, 3'd0, 32'h1234, 32'h1234, 32'd0, 1'b0);
    add_v(2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    add_v(2'b11, 7'h7F, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    add_v(2'b10, 7'h00, 3'd0, 32'd3, 32'd4, 32'd7, 1'b0);
    add_v(2'b10, 7'h20, 3'd0, 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b0);
    add_v(2'b10, 7'h00, 3'd1, 32'd1, 32'd33, 32'd2, 1'b0);
    add_v(2'b10, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    add_v(2'b10, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    add_v(2'b10, 7'h00, 3'd4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
    add_v(2'b10, 7'h00, 3'd5, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
    add_v(2'b10, 7'h00, 3'd6, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB, 1'b0);
    add_v(2'b10, 7'h00, 3'd7, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0);
    add_v(2'b10, 7'h20, 3'd2, 32'd9, 32'd9, 32'd0, 1'b1);
    add_v(2'b10, 7'h03, 3'd0, 32'd9, 32'd9, 32'd0, 1'b1);
    add_m(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33);
    add_m(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    add_m(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    add_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    add_m(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    add_m(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    add_m(3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    add_m(3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
    add_m(3'd5, 32'd100, 32'd7, 32'd14, 33);
    add_m(3'd7, 32'd100, 32'd7, 32'd2, 33);
    add_m(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    add_m(3'd7, 32'd7, 32'd0, 32'd7, 1);
    add_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    add_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", 32'(zero), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i])
      do_op(vt[i].op, vt[i].f7, vt[i].f3, vt[i].a, vt[i].b, vt[i].r, vt[i].ill, vt[i].lat,
            $sformatf("vec%0d", i));

    // Randomized ops against the model.
    for (int i = 0; i < 80; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2: rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) rop = 2'b10;
      rf3 = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      model(rop, rf7, rf3, ra, rb, er, eill, elat);
      do_op(rop, rf7, rf3, ra, rb, er, eill, elat, $sformatf("rnd%0d", i));
    end

    // Output hold under back-pressure, then drain-and-accept in one cycle.
    @(posedge clk);
    #1;
    @(negedge clk);
    out_ready = 1'b0;
    alu_op = 2'b00; op_a = 32'd100; op_b = 32'd23; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("hold first valid", 32'(out_valid), 32'd1);
    chk("hold first result", result, 32'd123);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d result", k), result, 32'd123);
      chk($sformatf("hold%0d valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    alu_op = 2'b00; op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1;
    #1;
    chk("drain_accept in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("drain_accept valid", 32'(out_valid), 32'd1);
    chk("drain_accept result", result, 32'd3);
    @(posedge clk);
    #1;
    chk("drain_accept cleared", 32'(out_valid), 32'd0);

    // Reset during a divide aborts it.
    @(negedge clk);
    alu_op = 2'b10; func7 = 7'h01; func3 = 3'd4; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("div busy before reset", 32'(busy), 32'(MD_EN));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort no stale result", 32'(out_valid), 32'd0);
    do_op(2'b10, 7'b0000011, 3'd0, 32'd55, 32'd66, 32'd0, 1'b1, 1, "post_reset illegal");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
